// File: rtl/dmem_dump_reader.sv
// Post-run data-memory dump: once all cores are done, reads a window of data
// memory and ships each word over UART 8N1, most-significant byte first.
module dmem_dump_reader #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR    = WIDTH'(1023),
  parameter int               WORD_COUNT   = 1024,
  parameter int               CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             proc_state,
  input  logic [WIDTH-1:0] mem_out,
  output logic             rEn,
  output logic [WIDTH-1:0] addr,
  output logic             dump_active,
  output logic             dump_done,
  output logic             tx
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
  localparam logic [WIDTH:0]    WC        = (WIDTH + 1)'(WORD_COUNT);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, START, DATA, STOP, DONE
  } state_t;

  state_t            state;
  logic              proc_state_p0;
  logic              proc_state_p1;
  logic [WIDTH-1:0]  idx;
  logic [BYTE_W-1:0] byte_idx;
  logic [2:0]        bit_idx;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  word_sr;
  logic [7:0]        cur_byte;
  logic              baud_end;
  logic              more_words;

  // Address arithmetic deliberately wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] i);
    return BASE_ADDR + i;
  endfunction

  assign cur_byte   = word_sr[WIDTH-1 -: 8];
  assign baud_end   = (cnt == BAUD_LAST);
  assign more_words = (({1'b0, idx} + 1'b1) < WC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      proc_state_p0 <= 1'b0;
      proc_state_p1 <= 1'b0;
      tx            <= 1'b1;
      rEn           <= 1'b0;
      addr          <= '0;
      dump_active   <= 1'b0;
      dump_done     <= 1'b0;
      idx           <= '0;
      byte_idx      <= '0;
      bit_idx       <= '0;
      cnt           <= '0;
    end else begin
      proc_state_p0 <= proc_state;
      proc_state_p1 <= proc_state_p0;
      case (state)
        IDLE: begin
          if (proc_state_p0 && !proc_state_p1) begin
            dump_active <= 1'b1;
            rEn         <= 1'b1;
            addr        <= word_addr('0);
            idx         <= '0;
            state       <= READ;
          end
        end
        READ: begin
          rEn   <= 1'b0;
          state <= LATCH;
        end
        LATCH: begin
          byte_idx <= '0;
          cnt      <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              tx       <= 1'b0;
              state    <= START;
            end else if (more_words) begin
              idx   <= idx + 1'b1;
              rEn   <= 1'b1;
              addr  <= word_addr(idx + 1'b1);
              state <= READ;
            end else begin
              dump_done   <= 1'b1;
              dump_active <= 1'b0;
              state       <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Re-arm only once the cores drop their done flags.
          if (!proc_state_p0) begin
            dump_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word shift register: loaded on LATCH, shifted up a byte after each non-final stop bit.
  always_ff @(posedge clk) begin
    if (state == LATCH) begin
      word_sr <= mem_out;
    end else if (state == STOP && baud_end && byte_idx != LAST_BYTE) begin
      word_sr <= word_sr << 8;
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader: dump contents, bit timing, wrap, re-arm, reset.
module tb_dmem_dump_reader;

  localparam int C   = 4;
  localparam int C_W = 2;

  logic        clk;
  logic        rst;
  logic        proc_state;
  logic [15:0] mem_out;
  logic        rEn;
  logic [15:0] addr;
  logic        dump_active;
  logic        dump_done;
  logic        tx;

  logic        proc_state_w;
  logic [15:0] mem_out_w;
  logic        rEn_w;
  logic [15:0] addr_w;
  logic        dump_active_w;
  logic        dump_done_w;
  logic        tx_w;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:2047];
  int          cyc = 0;
  int          ren_cyc[$];
  logic [15:0] ren_addr[$];
  int          done_cyc = -1;
  logic        done_prev = 1'b0;
  logic [15:0] w_addr[$];
  logic [7:0]  rx_q[$];

  dmem_dump_reader #(
    .WIDTH(16), .BASE_ADDR(16'd1023), .WORD_COUNT(2), .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk), .rst(rst), .proc_state(proc_state), .mem_out(mem_out),
    .rEn(rEn), .addr(addr), .dump_active(dump_active), .dump_done(dump_done), .tx(tx)
  );

  dmem_dump_reader #(
    .WIDTH(16), .BASE_ADDR(16'hFFFF), .WORD_COUNT(2), .CLKS_PER_BIT(C_W)
  ) dut_wrap (
    .clk(clk), .rst(rst), .proc_state(proc_state_w), .mem_out(mem_out_w),
    .rEn(rEn_w), .addr(addr_w), .dump_active(dump_active_w), .dump_done(dump_done_w), .tx(tx_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rEn) mem_out <= mem[addr[10:0]];
    if (rEn_w) mem_out_w <= addr_w ^ 16'h5A5A;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rEn) begin
      ren_cyc.push_back(cyc);
      ren_addr.push_back(addr);
    end
    if (dump_done && !done_prev) done_cyc = cyc;
    done_prev = dump_done;
    if (rEn_w) w_addr.push_back(addr_w);
  end

  // UART receiver: samples one cycle into each bit period.
  initial begin : uart_rx
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (tx === 1'b0 && !rst) begin
        repeat (C + 1) @(posedge clk);
        #1;
        b[0] = tx;
        for (int j = 1; j < 8; j++) begin
          repeat (C) @(posedge clk);
          #1;
          b[j] = tx;
        end
        repeat (C) @(posedge clk);
        #1;
        if (tx === 1'b1) rx_q.push_back(b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600; i++) begin
      if (dump_done) break;
      tick(1);
    end
    chk("done_reached", 32'(dump_done), 32'd1);
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    ren_addr.delete();
    rx_q.delete();
    done_cyc = -1;
  endtask

  task automatic chk_dump(input string tag, input logic [15:0] w0, input logic [15:0] w1);
    chk({tag, "_nbytes"}, 32'(rx_q.size()), 32'd4);
    chk({tag, "_b0"}, 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(w0[15:8]));
    chk({tag, "_b1"}, 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'(w0[7:0]));
    chk({tag, "_b2"}, 32'(rx_q.size() > 2 ? rx_q[2] : 8'hxx), 32'(w1[15:8]));
    chk({tag, "_b3"}, 32'(rx_q.size() > 3 ? rx_q[3] : 8'hxx), 32'(w1[7:0]));
    chk({tag, "_nreads"}, 32'(ren_addr.size()), 32'd2);
    chk({tag, "_addr0"}, 32'(ren_addr.size() > 0 ? ren_addr[0] : 16'hxxxx), 32'd1023);
    chk({tag, "_addr1"}, 32'(ren_addr.size() > 1 ? ren_addr[1] : 16'hxxxx), 32'd1024);
    chk({tag, "_len"}, 32'(ren_cyc.size() > 0 ? done_cyc - ren_cyc[0] : -1), 32'd164);
    chk({tag, "_active_low"}, 32'(dump_active), 32'd0);
  endtask

  logic [79:0] txw;
  logic [79:0] exp_w;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[1023] = 16'hA55A;
    mem[1024] = 16'h0102;
    for (int i = 0; i < 80; i++)
      exp_w[i] = !((i < 36) || (i >= 40 && i < 44));

    rst = 1'b1;
    proc_state = 1'b0;
    proc_state_w = 1'b0;
    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ren", 32'(rEn), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_active", 32'(dump_active), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    rst = 1'b0;
    tick(3);

    // Basic dump
    clear_logs();
    proc_state = 1'b1;
    wait_done();
    tick(1);
    chk_dump("basic", 16'hA55A, 16'h0102);

    // Hold done, then re-arm
    tick(100);
    chk("hold_no_read", 32'(ren_addr.size()), 32'd2);
    chk("hold_done", 32'(dump_done), 32'd1);
    proc_state = 1'b0;
    tick(2);
    chk("drop_clears_done", 32'(dump_done), 32'd0);
    tick(3);
    clear_logs();
    proc_state = 1'b1;
    wait_done();
    tick(1);
    chk_dump("rearm", 16'hA55A, 16'h0102);

    // Bit timing, with proc_state dropped during the second byte
    proc_state = 1'b0;
    tick(4);
    mem[1023] = 16'h00FF;
    clear_logs();
    proc_state = 1'b1;
    tick(1);
    chk("edge_ren_t0", 32'(rEn), 32'd0);
    chk("edge_tx_t0", 32'(tx), 32'd1);
    tick(1);
    chk("edge_ren_t1", 32'(rEn), 32'd1);
    chk("edge_active_t1", 32'(dump_active), 32'd1);
    chk("edge_addr_t1", 32'(addr), 32'd1023);
    tick(1);
    chk("edge_ren_t2", 32'(rEn), 32'd0);
    tick(1);
    for (int i = 0; i < 80; i++) begin
      txw[i] = tx;
      if (i == 50) proc_state = 1'b0;
      tick(1);
    end
    checks++;
    assert (txw === exp_w) else begin
      failures++;
      $error("FAIL bit_wave observed=%h expected=%h", txw, exp_w);
    end
    chk("gap_tx0", 32'(tx), 32'd1);
    chk("gap_ren", 32'(rEn), 32'd1);
    chk("gap_addr", 32'(addr), 32'd1024);
    tick(1);
    chk("gap_tx1", 32'(tx), 32'd1);
    tick(1);
    chk("gap_start", 32'(tx), 32'd0);
    wait_done();
    chk("mid_len", 32'(ren_cyc.size() > 0 ? done_cyc - ren_cyc[0] : -1), 32'd164);
    tick(1);
    chk("mid_done_exit", 32'(dump_done), 32'd0);
    chk("mid_nbytes", 32'(rx_q.size()), 32'd4);
    chk("mid_b0", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h00);
    chk("mid_b1", 32'(rx_q.size() > 1 ? rx_q[1] : 8'hxx), 32'hFF);

    // Address wrap
    proc_state_w = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (dump_done_w) break;
      tick(1);
    end
    chk("wrap_done", 32'(dump_done_w), 32'd1);
    chk("wrap_nreads", 32'(w_addr.size()), 32'd2);
    chk("wrap_addr0", 32'(w_addr.size() > 0 ? w_addr[0] : 16'hxxxx), 32'hFFFF);
    chk("wrap_addr1", 32'(w_addr.size() > 1 ? w_addr[1] : 16'hxxxx), 32'h0000);

    // Reset during a data bit
    tick(3);
    clear_logs();
    proc_state = 1'b1;
    tick(14);
    chk("pre_rst_active", 32'(dump_active), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_ren", 32'(rEn), 32'd0);
    chk("mid_rst_active", 32'(dump_active), 32'd0);
    chk("mid_rst_done", 32'(dump_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rEn) break;
      tick(1);
    end
    chk("restart_ren", 32'(rEn), 32'd1);
    chk("restart_addr", 32'(addr), 32'd1023);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
